// File: rtl/commit_fence_ctrl_if.sv
// commit_fence_ctrl_if: commit-port request, store-drain, cache/TLB flush and completion signals
interface commit_fence_ctrl_if;
    logic       req_valid_i;
    logic [1:0] req_type_i;
    logic       req_ready_o;
    logic       kill_i;
    logic       no_st_pending_i;
    logic       dcache_flush_o;
    logic       dcache_flush_ack_i;
    logic       icache_flush_o;
    logic       tlb_flush_o;
    logic       done_o;
    logic       flush_pipeline_o;
    logic       busy_o;
    logic       drain_timeout_o;

    modport slave (
        input  req_valid_i, req_type_i, kill_i, no_st_pending_i, dcache_flush_ack_i,
        output req_ready_o, dcache_flush_o, icache_flush_o, tlb_flush_o, done_o,
               flush_pipeline_o, busy_o, drain_timeout_o
    );

    modport master (
        output req_valid_i, req_type_i, kill_i, no_st_pending_i, dcache_flush_ack_i,
        input  req_ready_o, dcache_flush_o, icache_flush_o, tlb_flush_o, done_o,
               flush_pipeline_o, busy_o, drain_timeout_o
    );
endinterface

// File: rtl/commit_fence_ctrl.sv
// commit_fence_ctrl: sequences FENCE / FENCE_I / SFENCE_VMA through store drain, cache/TLB flush and commit
module commit_fence_ctrl #(
    parameter int unsigned DRAIN_TIMEOUT = 1024
) (
    input logic                   clk_i,
    input logic                   rst_ni,
    commit_fence_ctrl_if.slave    bus
);
    localparam logic [1:0] OP_FENCE  = 2'b00;
    localparam logic [1:0] OP_FENCEI = 2'b01;
    localparam logic [1:0] OP_SFENCE = 2'b10;
    localparam logic [15:0] LIMIT = 16'(DRAIN_TIMEOUT);

    typedef enum logic [2:0] {IDLE, DRAIN, DFLUSH, IFLUSH, TLB, DONE} state_t;

    state_t      state, state_nxt;
    logic [1:0]  op, op_nxt;
    logic [15:0] cnt, cnt_nxt;
    logic        timeout;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state <= IDLE;
            op    <= OP_FENCE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            op    <= op_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        op_nxt    = op;
        cnt_nxt   = cnt;
        timeout   = 1'b0;
        case (state)
            IDLE: if (bus.req_valid_i && bus.req_ready_o) begin
                op_nxt    = (bus.req_type_i == 2'b11) ? OP_FENCE : bus.req_type_i;
                cnt_nxt   = '0;
                state_nxt = DRAIN;
            end
            DRAIN: begin
                if (bus.kill_i)
                    state_nxt = IDLE;
                else if (bus.no_st_pending_i)
                    state_nxt = (op == OP_SFENCE) ? TLB : DFLUSH;
                else begin
                    // counter parks at LIMIT so the pulse at LIMIT-1 never repeats
                    cnt_nxt = (cnt == LIMIT) ? cnt : cnt + 16'd1;
                    timeout = (cnt == LIMIT - 16'd1);
                end
            end
            DFLUSH: if (bus.dcache_flush_ack_i) state_nxt = (op == OP_FENCEI) ? IFLUSH : DONE;
            IFLUSH: state_nxt = DONE;
            TLB:    state_nxt = DONE;
            DONE:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign bus.req_ready_o      = (state == IDLE) & ~bus.kill_i;
    assign bus.busy_o           = (state != IDLE);
    assign bus.dcache_flush_o   = (state == DFLUSH);
    assign bus.icache_flush_o   = (state == IFLUSH);
    assign bus.tlb_flush_o      = (state == TLB);
    assign bus.done_o           = (state == DONE);
    assign bus.flush_pipeline_o = (state == DONE);
    assign bus.drain_timeout_o  = timeout;
endmodule

// File: doc/commit_fence_ctrl.md
COMMIT_FENCE_CTRL -- requirements
Module: commit_fence_ctrl

Interface
REQ-001 Parameter DRAIN_TIMEOUT, default 1024, meaning: number of DRAIN cycles without no_st_pending_i before drain_timeout_o pulses; legal range 2..65535.
REQ-002 Clock and reset SHALL be: clk_i input 1, the single clock; rst_ni input 1, asynchronous active-low reset.
REQ-003 req_valid_i input 1: commit port 0 holds a fence-class instruction.
REQ-004 req_type_i input 2: operation type. 2'b00 FENCE, 2'b01 FENCE_I, 2'b10 SFENCE_VMA, 2'b11 reserved.
REQ-005 req_ready_o output 1: request accepted this cycle.
REQ-006 kill_i input 1: halt or exception flush request.
REQ-007 no_st_pending_i input 1: store buffer empty.
REQ-008 dcache_flush_o output 1: D$ flush request, level.
REQ-009 dcache_flush_ack_i input 1: D$ flush complete, one-cycle pulse.
REQ-010 icache_flush_o output 1: I$ flush, one-cycle pulse.
REQ-011 tlb_flush_o output 1: TLB flush, one-cycle pulse.
REQ-012 done_o output 1: commit acknowledge for the fence, one-cycle pulse.
REQ-013 flush_pipeline_o output 1: pipeline flush request, one-cycle pulse.
REQ-014 busy_o output 1: controller not idle.
REQ-015 drain_timeout_o output 1: drain watchdog fired, one-cycle pulse.

Function
REQ-016 The FSM SHALL use six states: IDLE, DRAIN, DFLUSH, IFLUSH, TLB, DONE.
REQ-017 req_ready_o SHALL equal (state==IDLE) & ~kill_i.
- A request is accepted when req_valid_i & req_ready_o.
- On acceptance, req_type_i is latched, with 2'b11 latched as FENCE.
- The drain counter is cleared and the FSM goes to DRAIN.
REQ-018 DRAIN SHALL behave as follows.
- If no_st_pending_i: FENCE and FENCE_I go to DFLUSH; SFENCE_VMA goes to TLB.
- Otherwise the counter increments, saturating at DRAIN_TIMEOUT.
- drain_timeout_o pulses exactly once, in the cycle the counter reaches DRAIN_TIMEOUT-1.
- The FSM keeps waiting after the pulse.
REQ-019 DFLUSH SHALL hold dcache_flush_o=1 from entry through the cycle dcache_flush_ack_i is seen.
- On ack, FENCE goes to DONE and FENCE_I goes to IFLUSH.
- The ack is honoured in the first DFLUSH cycle.
REQ-020 IFLUSH SHALL assert icache_flush_o for exactly one cycle, then go to DONE.
REQ-021 TLB SHALL assert tlb_flush_o for exactly one cycle, then go to DONE.
REQ-022 DONE SHALL assert done_o and flush_pipeline_o for exactly one cycle, then go to IDLE.
REQ-023 busy_o SHALL be combinational (state!=IDLE).
REQ-024 dcache_flush_o, icache_flush_o, tlb_flush_o, done_o and flush_pipeline_o SHALL be decoded from state only, with no combinational path from inputs.
REQ-025 kill_i SHALL be handled per state.
- In IDLE or DRAIN: go to IDLE next cycle with no flush, done or timeout output.
- In DFLUSH: no effect; the D$ handshake always completes.
- In IFLUSH, TLB or DONE: no effect; the sequence completes.
REQ-026 dcache_flush_ack_i outside DFLUSH SHALL be ignored.
REQ-027 req_valid_i while busy SHALL be ignored and not queued.
REQ-028 Minimum accept-to-done_o latency SHALL be 3 cycles for all types, plus 1 for FENCE_I.
REQ-029 At most one of dcache_flush_o, icache_flush_o, tlb_flush_o, done_o SHALL be high in any cycle.

Reset
REQ-030 While rst_ni=0, and asynchronously on assertion, the block SHALL reset.
- State goes to IDLE, the counter to 0 and the latched type to FENCE.
- All outputs go to 0, except req_ready_o, which follows REQ-017 (1 when kill_i=0).
REQ-031 Reset asserted mid-sequence, including during DFLUSH, SHALL abandon the sequence with no pulse on release.

Verification
REQ-032 The bench SHALL cover these scenarios.
- FENCE, no_st_pending_i=1, ack in the first DFLUSH cycle: accept c0, dcache_flush_o c2, done_o and flush_pipeline_o c3, busy_o c1..c3.
- FENCE_I, stores pending 5 cycles, ack 4 cycles after DFLUSH entry: dcache_flush_o high 5 cycles, icache_flush_o one cycle, then done_o one cycle.
- SFENCE_VMA, no_st_pending_i=1: tlb_flush_o c2, done_o c3, dcache_flush_o never high.
- DRAIN_TIMEOUT=4, no_st_pending_i=0 for 10 cycles, then 1: drain_timeout_o pulses once at DRAIN cycle 4, then normal completion.
- kill_i in DRAIN: IDLE next cycle, no done_o. kill_i in DFLUSH: dcache_flush_o held until ack, done_o still pulses.
- rst_ni asserted in DFLUSH: all outputs 0 immediately; after release busy_o=0, req_ready_o=1.
